// File: rtl/image_page_ctrl_pkg.sv
// Shared types and constants for the image page sequencer/arbiter.
// Holds the controller state encoding and the 3x3 window tap geometry.
package image_page_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_EMPTY,
    ST_LOAD,
    ST_READY,
    ST_FETCH,
    ST_DRAIN
  } state_t;

  localparam int TAPS      = 9;
  localparam int TAP_LAST  = TAPS - 1;
  localparam int DEF_IMG_W = 64;
  localparam int DEF_IMG_H = 64;
  localparam int DEF_PIX_W = 8;
  localparam int PAD_VALUE = 0;

  // Row offset of tap k: taps 0-2 sit one row above the centre, 6-8 one below.
  function automatic logic signed [1:0] tap_dr(input logic [3:0] k);
    case (k)
      4'd0, 4'd1, 4'd2: tap_dr = -2'sd1;
      4'd3, 4'd4, 4'd5: tap_dr = 2'sd0;
      default:          tap_dr = 2'sd1;
    endcase
  endfunction

  function automatic logic signed [1:0] tap_dc(input logic [3:0] k);
    case (k)
      4'd0, 4'd3, 4'd6: tap_dc = -2'sd1;
      4'd1, 4'd4, 4'd7: tap_dc = 2'sd0;
      default:          tap_dc = 2'sd1;
    endcase
  endfunction

endpackage

// File: rtl/image_page_ctrl_win_tap_addr.sv
// Maps (centre row, centre col, tap index) to a page RAM address.
// Padding taps report in_range=0 and a zero address.
module win_tap_addr
  import image_page_ctrl_pkg::*;
#(
  parameter int IMG_W     = DEF_IMG_W,
  parameter int IMG_H     = DEF_IMG_H,
  parameter int ADDR_W    = 13,
  parameter int BASE_ADDR = 0
) (
  input  logic [7:0]        row,
  input  logic [7:0]        col,
  input  logic [3:0]        k,
  output logic              in_range,
  output logic [ADDR_W-1:0] addr
);

  localparam logic signed [9:0] H_LIM = 10'(IMG_H);
  localparam logic signed [9:0] W_LIM = 10'(IMG_W);

  logic signed [1:0] dr;
  logic signed [1:0] dc;
  logic signed [9:0] r;
  logic signed [9:0] c;

  always_comb begin
    dr = tap_dr(k);
    dc = tap_dc(k);
    r  = $signed({2'b00, row}) + {{8{dr[1]}}, dr};
    c  = $signed({2'b00, col}) + {{8{dc[1]}}, dc};
    in_range = (r >= 10'sd0) && (r < H_LIM) && (c >= 10'sd0) && (c < W_LIM);
    addr = '0;
    if (in_range)
      addr = ADDR_W'(BASE_ADDR) + ADDR_W'(r[8:0]) * ADDR_W'(IMG_W) + ADDR_W'(c[8:0]);
  end

endmodule

// File: rtl/image_page_ctrl.sv
// Page RAM sequencer: raster loader writes a page, then 3x3 zero-padded
// windows are read out tap by tap for the conv engine, one per 11 cycles.
module image_page_ctrl
  import image_page_ctrl_pkg::*;
#(
  parameter int IMG_W     = DEF_IMG_W,
  parameter int IMG_H     = DEF_IMG_H,
  parameter int ADDR_W    = 13,
  parameter int PIX_W     = DEF_PIX_W,
  parameter int BASE_ADDR = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load_start,
  input  logic                 load_valid,
  input  logic [PIX_W-1:0]     load_data,
  output logic                 load_ready,
  output logic                 load_done,
  input  logic                 fetch_req,
  input  logic [7:0]           fetch_row,
  input  logic [7:0]           fetch_col,
  output logic                 fetch_ack,
  output logic                 win_valid,
  output logic [9*PIX_W-1:0]   win_data,
  output logic [ADDR_W-1:0]    mem_addr,
  output logic                 mem_we,
  output logic [PIX_W-1:0]     mem_wdata,
  output logic                 mem_rd,
  input  logic [PIX_W-1:0]     mem_rdata,
  output logic                 busy
);

  localparam logic [ADDR_W-1:0] LAST_PIX = ADDR_W'(IMG_W * IMG_H - 1);
  localparam logic [PIX_W-1:0]  PAD      = PIX_W'(PAD_VALUE);

  state_t               state;
  logic [ADDR_W-1:0]    wptr;
  logic [3:0]           tap;
  logic [3:0]           cap_tap;
  logic                 cap_en;
  logic                 cap_rd;
  logic [7:0]           row_q;
  logic [7:0]           col_q;
  logic                 defer;
  logic [8*PIX_W-1:0]   acc;
  logic                 tap_in_range;
  logic [ADDR_W-1:0]    tap_addr;

  win_tap_addr #(
    .IMG_W     (IMG_W),
    .IMG_H     (IMG_H),
    .ADDR_W    (ADDR_W),
    .BASE_ADDR (BASE_ADDR)
  ) u_tap_addr (
    .row      (row_q),
    .col      (col_q),
    .k        (tap),
    .in_range (tap_in_range),
    .addr     (tap_addr)
  );

  always_comb begin
    load_ready = (state == ST_LOAD);
    mem_we     = load_valid & load_ready;
    mem_wdata  = load_ready ? load_data : '0;
    mem_rd     = (state == ST_FETCH) & tap_in_range;
    busy       = (state == ST_LOAD) || (state == ST_FETCH) || (state == ST_DRAIN);
    mem_addr   = '0;
    if (load_ready)
      mem_addr = ADDR_W'(BASE_ADDR) + wptr;
    else if (mem_rd)
      mem_addr = tap_addr;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_EMPTY;
      wptr      <= '0;
      tap       <= '0;
      cap_tap   <= '0;
      cap_en    <= 1'b0;
      cap_rd    <= 1'b0;
      row_q     <= '0;
      col_q     <= '0;
      defer     <= 1'b0;
      load_done <= 1'b0;
      fetch_ack <= 1'b0;
      win_valid <= 1'b0;
      acc       <= '0;
      win_data  <= '0;
    end else begin
      fetch_ack <= 1'b0;
      win_valid <= 1'b0;
      // Read data lags its tap slot by one cycle; remember which tap and
      // whether it was a real read so padding taps never sample the RAM bus.
      cap_en    <= (state == ST_FETCH);
      cap_tap   <= tap;
      cap_rd    <= mem_rd;
      if (cap_en && !cap_tap[3])
        acc[int'(cap_tap[2:0])*PIX_W +: PIX_W] <= cap_rd ? mem_rdata : PAD;

      case (state)
        ST_EMPTY: begin
          if (load_start) begin
            wptr  <= '0;
            state <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          if (load_start) begin
            wptr <= '0;
          end else if (mem_we) begin
            if (wptr == LAST_PIX) begin
              wptr      <= '0;
              load_done <= 1'b1;
              state     <= ST_READY;
            end else begin
              wptr <= wptr + 1'b1;
            end
          end
        end
        ST_READY: begin
          if (load_start || defer) begin
            defer     <= 1'b0;
            load_done <= 1'b0;
            wptr      <= '0;
            state     <= ST_LOAD;
          end else if (fetch_req) begin
            row_q     <= fetch_row;
            col_q     <= fetch_col;
            tap       <= '0;
            fetch_ack <= 1'b1;
            state     <= ST_FETCH;
          end
        end
        ST_FETCH: begin
          if (load_start)
            defer <= 1'b1;
          if (tap == 4'(TAP_LAST)) begin
            tap   <= '0;
            state <= ST_DRAIN;
          end else begin
            tap <= tap + 1'b1;
          end
        end
        ST_DRAIN: begin
          if (load_start)
            defer <= 1'b1;
          win_data  <= {(cap_rd ? mem_rdata : PAD), acc};
          win_valid <= 1'b1;
          state     <= ST_READY;
        end
        default: state <= ST_EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_image_page_ctrl.sv
// Self-checking bench for image_page_ctrl on an 8x8 page with a RAM model
// and a window reference computed directly from the loaded image.
module tb_image_page_ctrl;

  localparam int W  = 8;
  localparam int H  = 8;
  localparam int AW = 13;
  localparam int PW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          load_start = 1'b0;
  logic          load_valid = 1'b0;
  logic [PW-1:0] load_data = '0;
  logic          load_ready;
  logic          load_done;
  logic          fetch_req = 1'b0;
  logic [7:0]    fetch_row = '0;
  logic [7:0]    fetch_col = '0;
  logic          fetch_ack;
  logic          win_valid;
  logic [71:0]   win_data;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [PW-1:0] mem_wdata;
  logic          mem_rd;
  logic [PW-1:0] mem_rdata = '0;
  logic          busy;

  image_page_ctrl #(
    .IMG_W     (W),
    .IMG_H     (H),
    .ADDR_W    (AW),
    .PIX_W     (PW),
    .BASE_ADDR (0)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_start (load_start),
    .load_valid (load_valid),
    .load_data  (load_data),
    .load_ready (load_ready),
    .load_done  (load_done),
    .fetch_req  (fetch_req),
    .fetch_row  (fetch_row),
    .fetch_col  (fetch_col),
    .fetch_ack  (fetch_ack),
    .win_valid  (win_valid),
    .win_data   (win_data),
    .mem_addr   (mem_addr),
    .mem_we     (mem_we),
    .mem_wdata  (mem_wdata),
    .mem_rd     (mem_rd),
    .mem_rdata  (mem_rdata),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  logic [7:0] ram [0:63];
  logic [7:0] img [0:63];
  int n_tests = 0;
  int n_fail  = 0;
  int overlap = 0;
  int idle_err = 0;

  // Registered-read RAM; garbage on non-read cycles exposes padding faults.
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr[5:0]] <= mem_wdata;
    if (mem_rd) mem_rdata <= ram[mem_addr[5:0]];
    else        mem_rdata <= 8'($urandom);
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (mem_we && mem_rd) overlap++;
      if (!mem_we && !mem_rd && !load_ready && mem_addr != '0) idle_err++;
    end
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    #1;
  endtask

  function automatic logic [71:0] ref_win(input int r, input int c);
    logic [71:0] w = '0;
    for (int k = 0; k < 9; k++) begin
      int rr = r + k / 3 - 1;
      int cc = c + k % 3 - 1;
      if (rr >= 0 && rr < H && cc >= 0 && cc < W) w[k*8 +: 8] = img[rr*W + cc];
    end
    return w;
  endfunction

  function automatic logic [8:0] ref_mask(input int r, input int c);
    logic [8:0] m = '0;
    for (int k = 0; k < 9; k++) begin
      int rr = r + k / 3 - 1;
      int cc = c + k % 3 - 1;
      m[k] = (rr >= 0 && rr < H && cc >= 0 && cc < W);
    end
    return m;
  endfunction

  task automatic do_load(input bit send_start, input bit raster,
                         output int we_cnt, output int err);
    int beat = 0;
    we_cnt = 0;
    err = 0;
    if (send_start) begin
      step; load_start = 1'b1; settle;
      step; load_start = 1'b0; settle;
    end
    for (int cyc = 0; cyc < 400 && beat < W*H; cyc++) begin
      step;
      load_valid = raster ? cyc[0] : 1'($urandom);
      load_data  = raster ? 8'(beat) : 8'($urandom);
      settle;
      if (mem_we !== load_valid) err++;
      if (mem_we) begin
        we_cnt++;
        if (mem_addr !== AW'(beat) || mem_wdata !== load_data) err++;
      end
      if (load_valid) begin
        img[beat] = load_data;
        beat++;
      end
    end
    step; load_valid = 1'b0; settle;
  endtask

  task automatic run_fetch(input logic [7:0] r, input logic [7:0] c, output bit acked,
                           output int lat, output logic [8:0] mask, output logic [71:0] win);
    acked = 1'b0;
    lat = -1;
    mask = '0;
    win = '0;
    step; fetch_req = 1'b1; fetch_row = r; fetch_col = c; settle;
    for (int i = 0; i < 6 && !acked; i++) begin
      step; settle;
      if (fetch_ack) acked = 1'b1;
    end
    if (!acked) begin
      fetch_req = 1'b0;
      return;
    end
    mask[0] = mem_rd;
    fetch_req = 1'b0;
    for (int j = 1; j <= 14; j++) begin
      step; settle;
      if (j < 9) mask[j] = mem_rd;
      if (win_valid) begin
        lat = j;
        win = win_data;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) step;
    settle;
    n_tests++;
    if ({busy, load_ready, load_done, fetch_ack, win_valid, mem_we, mem_rd} !== 7'b0) begin
      n_fail++;
      $display("FAIL reset_flags got=%b exp=0", {busy, load_ready, load_done, fetch_ack, win_valid, mem_we, mem_rd});
    end
    n_tests++;
    if (mem_addr !== '0 || win_data !== '0) begin
      n_fail++;
      $display("FAIL reset_data addr=%h win=%h exp=0", mem_addr, win_data);
    end
    rst_n = 1'b1;
    fetch_req = 1'b1;
    begin
      int acks = 0;
      for (int i = 0; i < 6; i++) begin
        step; settle;
        if (fetch_ack) acks++;
      end
      n_tests++;
      if (acks != 0) begin
        n_fail++;
        $display("FAIL empty_no_ack got=%0d exp=0", acks);
      end
    end
    fetch_req = 1'b0;
  endtask

  task automatic test_load;
    int we_cnt, err;
    do_load(1'b1, 1'b1, we_cnt, err);
    n_tests++;
    if (we_cnt != 64) begin
      n_fail++;
      $display("FAIL load_we_count got=%0d exp=64", we_cnt);
    end
    n_tests++;
    if (err != 0) begin
      n_fail++;
      $display("FAIL load_beats errors=%0d exp=0", err);
    end
    n_tests++;
    if ({load_done, load_ready, busy} !== 3'b100) begin
      n_fail++;
      $display("FAIL load_done_state got=%b exp=100", {load_done, load_ready, busy});
    end
  endtask

  task automatic test_fixed_windows;
    logic [7:0]  rows [4] = '{8'd3, 8'd0, 8'd7, 8'd200};
    logic [7:0]  cols [4] = '{8'd3, 8'd0, 8'd7, 8'd3};
    logic [71:0] exp_w [4] = '{72'h2423221C1B1A141312, 72'h090800010000000000,
                               72'h000000003F3E003736, 72'h0};
    logic [8:0]  exp_m [4] = '{9'h1FF, 9'h1B0, 9'h01B, 9'h000};
    for (int t = 0; t < 4; t++) begin
      bit acked;
      int lat;
      logic [8:0] mask;
      logic [71:0] win;
      run_fetch(rows[t], cols[t], acked, lat, mask, win);
      n_tests++;
      if (!acked || lat != 10) begin
        n_fail++;
        $display("FAIL fixed_latency[%0d] ack=%0d lat=%0d exp=10", t, acked, lat);
      end
      n_tests++;
      if (win !== exp_w[t]) begin
        n_fail++;
        $display("FAIL fixed_window[%0d] got=%h exp=%h", t, win, exp_w[t]);
      end
      n_tests++;
      if (mask !== exp_m[t]) begin
        n_fail++;
        $display("FAIL fixed_rd_mask[%0d] got=%b exp=%b", t, mask, exp_m[t]);
      end
    end
    step; settle;
    n_tests++;
    if (win_valid !== 1'b0 || win_data !== 72'h0) begin
      n_fail++;
      $display("FAIL window_hold valid=%b data=%h exp=0/0", win_valid, win_data);
    end
  endtask

  task automatic test_random_fetch(input int n);
    for (int t = 0; t < n; t++) begin
      bit acked;
      int lat;
      logic [8:0] mask;
      logic [71:0] win;
      logic [7:0] r, c;
      r = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 9));
      c = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 9));
      run_fetch(r, c, acked, lat, mask, win);
      n_tests++;
      if (!acked || lat != 10 || win !== ref_win(r, c) || mask !== ref_mask(r, c)) begin
        n_fail++;
        $display("FAIL random_window(%0d,%0d) ack=%0d lat=%0d got=%h exp=%h mask=%b exp=%b",
                 r, c, acked, lat, win, ref_win(r, c), mask, ref_mask(r, c));
      end
    end
  endtask

  task automatic test_deferred_load;
    bit acked = 1'b0;
    int acks = 0;
    int early = 0;
    int we_cnt, err;
    logic [71:0] exp_w;
    exp_w = ref_win(3, 3);
    step; fetch_req = 1'b1; fetch_row = 8'd3; fetch_col = 8'd3; settle;
    for (int i = 0; i < 6 && !acked; i++) begin
      step; settle;
      if (fetch_ack) acked = 1'b1;
    end
    n_tests++;
    if (!acked) begin
      n_fail++;
      $display("FAIL deferred_ack got=0 exp=1");
    end
    for (int j = 1; j <= 10; j++) begin
      step;
      load_start = (j == 3);
      settle;
      if (j < 10 && win_valid) early++;
    end
    n_tests++;
    if (early != 0 || win_valid !== 1'b1 || win_data !== exp_w) begin
      n_fail++;
      $display("FAIL deferred_window early=%0d valid=%b got=%h exp=%h", early, win_valid, win_data, exp_w);
    end
    step; settle;
    n_tests++;
    if ({load_ready, load_done, fetch_ack} !== 3'b100) begin
      n_fail++;
      $display("FAIL deferred_enter_load got=%b exp=100", {load_ready, load_done, fetch_ack});
    end
    for (int i = 0; i < 3; i++) begin
      step; settle;
      if (fetch_ack) acks++;
    end
    fetch_req = 1'b0;
    n_tests++;
    if (acks != 0) begin
      n_fail++;
      $display("FAIL load_ignores_fetch acks=%0d exp=0", acks);
    end
    do_load(1'b0, 1'b0, we_cnt, err);
    n_tests++;
    if (we_cnt != 64 || err != 0 || load_done !== 1'b1) begin
      n_fail++;
      $display("FAIL reload we=%0d err=%0d done=%b exp=64/0/1", we_cnt, err, load_done);
    end
  endtask

  task automatic test_back_to_back;
    int ack_t[$];
    int bad_gap = 0;
    step;
    fetch_req = 1'b1;
    fetch_row = 8'($urandom_range(0, 7));
    fetch_col = 8'($urandom_range(0, 7));
    settle;
    for (int cyc = 0; cyc < 40; cyc++) begin
      step; settle;
      if (fetch_ack) ack_t.push_back(cyc);
    end
    fetch_req = 1'b0;
    for (int i = 1; i < ack_t.size(); i++)
      if (ack_t[i] - ack_t[i-1] != 11) bad_gap++;
    n_tests++;
    if (ack_t.size() < 3 || bad_gap != 0) begin
      n_fail++;
      $display("FAIL back_to_back acks=%0d bad_gaps=%0d exp>=3/0", ack_t.size(), bad_gap);
    end
    repeat (14) step;
  endtask

  task automatic test_reset_mid_fetch;
    bit acked = 1'b0;
    int acks = 0;
    int wins = 0;
    step; fetch_req = 1'b1; fetch_row = 8'd5; fetch_col = 8'd5; settle;
    for (int i = 0; i < 6 && !acked; i++) begin
      step; settle;
      if (fetch_ack) acked = 1'b1;
    end
    fetch_req = 1'b0;
    repeat (5) step;
    settle;
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (!acked || {busy, load_done, load_ready, fetch_ack, win_valid, mem_rd, mem_we} !== 7'b0
        || mem_addr !== '0 || win_data !== '0) begin
      n_fail++;
      $display("FAIL reset_mid_fetch ack=%0d flags=%b addr=%h win=%h exp=0", acked,
               {busy, load_done, load_ready, fetch_ack, win_valid, mem_rd, mem_we}, mem_addr, win_data);
    end
    repeat (2) step;
    rst_n = 1'b1;
    fetch_req = 1'b1;
    for (int i = 0; i < 15; i++) begin
      step; settle;
      if (fetch_ack) acks++;
      if (win_valid) wins++;
    end
    fetch_req = 1'b0;
    n_tests++;
    if (acks != 0 || wins != 0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL after_reset acks=%0d wins=%0d busy=%b exp=0/0/0", acks, wins, busy);
    end
  endtask

  initial begin
    test_reset;
    test_load;
    test_fixed_windows;
    test_random_fetch(12);
    test_deferred_load;
    test_random_fetch(8);
    test_back_to_back;
    test_reset_mid_fetch;
    n_tests++;
    if (overlap != 0 || idle_err != 0) begin
      n_fail++;
      $display("FAIL bus_rules we_rd_overlap=%0d idle_addr=%0d exp=0/0", overlap, idle_err);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
